// File: rtl/ysyx_25040129_arbiter.sv
// Two-master AXI4 arbiter: IFU (burst reads) and LSU (single-beat read/write) share one
// memory port, one whole transaction at a time, round-robin under contention.
module ysyx_25040129_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  // IFU read-only master
  input  logic [31:0] ifu_araddr,
  input  logic [2:0]  ifu_arsize,
  input  logic [7:0]  ifu_arlen,
  input  logic [1:0]  ifu_arburst,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  // LSU single-beat master
  input  logic [31:0] lsu_araddr,
  input  logic [2:0]  lsu_arsize,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  input  logic [31:0] lsu_awaddr,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  // shared downstream port
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arsize,
  output logic [7:0]  m_arlen,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        timeout_err
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    IFU_RD,
    LSU_RD,
    LSU_WR
  } state_t;

  state_t           state;
  logic             last_ifu;
  logic [CNT_W-1:0] wd_cnt;

  logic r_ifu, r_lw, r_lr, r_lsu, done;

  // A write needs both address and data valid; within the LSU a write beats a read.
  assign r_ifu = ifu_arvalid;
  assign r_lw  = lsu_awvalid && lsu_wvalid;
  assign r_lr  = lsu_arvalid && !r_lw;
  assign r_lsu = r_lw || r_lr;

  always_comb begin
    case (state)
      IFU_RD:  done = m_rvalid && ifu_rready && m_rlast;
      LSU_RD:  done = m_rvalid && lsu_rready;
      LSU_WR:  done = m_bvalid && lsu_bready;
      default: done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      state       <= IDLE;
      last_ifu    <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Watchdog saturates at the limit so a hung transaction never wraps the count.
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else if (wd_cnt != TO_LIM) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (state != IDLE && wd_cnt == TO_LIM - CNT_W'(1)) begin
        timeout_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (r_ifu && (!r_lsu || !last_ifu)) begin
            state    <= IFU_RD;
            last_ifu <= 1'b1;
          end else if (r_lw) begin
            state    <= LSU_WR;
            last_ifu <= 1'b0;
          end else if (r_lr) begin
            state    <= LSU_RD;
            last_ifu <= 1'b0;
          end
        end
        default: begin
          if (done) state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output takes a default first, so no path through the case infers a latch.
    m_araddr    = '0;
    m_arsize    = '0;
    m_arlen     = '0;
    m_arburst   = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    case (state)
      IFU_RD: begin
        m_araddr    = ifu_araddr;
        m_arsize    = ifu_arsize;
        m_arlen     = ifu_arlen;
        m_arburst   = ifu_arburst;
        m_arvalid   = ifu_arvalid;
        ifu_arready = m_arready;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
      end
      LSU_RD: begin
        // LSU reads are always a single INCR beat.
        m_araddr    = lsu_araddr;
        m_arsize    = lsu_arsize;
        m_arlen     = 8'd0;
        m_arburst   = 2'b01;
        m_arvalid   = lsu_arvalid;
        lsu_arready = m_arready;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
      end
      LSU_WR: begin
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid;
        lsu_awready = m_awready;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid;
        lsu_wready  = m_wready;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid;
        m_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040129_arbiter.sv
// Bench for ysyx_25040129_arbiter: directed scenarios plus randomized rounds, each grant
// predicted from a request/grant-history model of the round-robin rules.
module tb_ysyx_25040129_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic [2:0]  ifu_arsize;
  logic [7:0]  ifu_arlen;
  logic [1:0]  ifu_arburst;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast, ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid, lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic [7:0]  m_arlen;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        timeout_err;

  ysyx_25040129_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen),
    .ifu_arburst(ifu_arburst), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pending requests as the masters see them, plus grant history (0 = IFU, 1 = LSU).
  logic        pend_ifu, pend_lr, pend_lw;
  logic [31:0] ifu_addr, lr_addr, lw_addr, lw_data;
  logic [7:0]  ifu_len;
  logic [2:0]  ifu_size, lr_size;
  logic [1:0]  ifu_burst;
  logic [3:0]  lw_strb;
  int          fix_resp = -1;
  int          grants[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_masters();
    ifu_arvalid = pend_ifu;
    ifu_araddr  = ifu_addr;
    ifu_arsize  = ifu_size;
    ifu_arlen   = ifu_len;
    ifu_arburst = ifu_burst;
    lsu_arvalid = pend_lr;
    lsu_araddr  = lr_addr;
    lsu_arsize  = lr_size;
    lsu_awvalid = pend_lw;
    lsu_wvalid  = pend_lw;
    lsu_awaddr  = lw_addr;
    lsu_wdata   = lw_data;
    lsu_wstrb   = lw_strb;
  endtask

  task automatic req_ifu(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    pend_ifu = 1'b1; ifu_addr = a; ifu_len = len; ifu_burst = burst; ifu_size = 3'd2;
  endtask

  task automatic req_lr(input logic [31:0] a, input logic [2:0] size);
    pend_lr = 1'b1; lr_addr = a; lr_size = size;
  endtask

  task automatic req_lw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    pend_lw = 1'b1; lw_addr = a; lw_data = d; lw_strb = s;
  endtask

  function automatic logic [1:0] pick_resp();
    return (fix_resp >= 0) ? 2'(fix_resp) : 2'($urandom_range(0, 3));
  endfunction

  // Starts in an IDLE cycle (posedge+1); runs one grant through to the next IDLE cycle.
  // waits < 0 picks a random stall count that keeps the grant under the 8-cycle watchdog.
  task automatic serve(input int waits);
    int          win;
    int          nbeats;
    logic [31:0] d;
    logic [1:0]  rs;
    logic        v, lst;
    drive_masters();
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b11;
    m_rdata = $urandom; m_rresp = 2'b11;
    ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
    #1;
    check("idle_gate", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, ifu_arready,
                        lsu_arready, lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid,
                        lsu_bvalid}, '0);
    check("idle_addr", {m_araddr, m_awaddr}, '0);
    check("idle_data", {m_wdata, m_wstrb, m_arlen, m_arsize, m_arburst, ifu_rdata[14:0]}, '0);
    check("no_timeout", timeout_err, 1'b0);

    // Tie goes to whoever did not win the previous grant; the IFU wins from reset.
    if (pend_ifu && (!(pend_lr || pend_lw) || grants.size() == 0 || grants[$] != 0)) win = 0;
    else if (pend_lw) win = 2;
    else win = 1;
    grants.push_back(win == 0 ? 0 : 1);

    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
    #1;
    case (win)
      0: begin
        check("ifu_ar", {m_arvalid, m_araddr, m_arsize, m_arlen, m_arburst},
              {1'b1, ifu_addr, ifu_size, ifu_len, ifu_burst});
        check("ifu_grant", {ifu_arready, lsu_arready, lsu_awready, lsu_wready, m_awvalid,
                            m_wvalid}, 6'b100000);
        tick();
        pend_ifu = 1'b0; drive_masters(); m_arready = 1'b0;
        nbeats = int'(ifu_len) + 1;
        if (waits < 0) waits = $urandom_range(0, 6 - nbeats);
        repeat (waits) begin
          v = 1'($urandom_range(0, 1));
          m_rvalid = v; m_rlast = 1'b1; ifu_rready = 1'b0;
          #1;
          check("ifu_stall", {m_rready, ifu_rvalid, ifu_rlast}, {1'b0, v, 1'b1});
          tick();
        end
        for (int b = 0; b < nbeats; b++) begin
          d = $urandom; rs = pick_resp(); lst = (b == nbeats - 1);
          m_rvalid = 1'b1; m_rdata = d; m_rresp = rs; m_rlast = lst; ifu_rready = 1'b1;
          #1;
          check("ifu_r", {ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast, m_rready},
                {1'b1, d, rs, lst, 1'b1});
          check("ifu_r_other", {lsu_rvalid, lsu_rdata, lsu_bvalid}, '0);
          tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; ifu_rready = 1'b0;
      end
      1: begin
        check("lr_ar", {m_arvalid, m_araddr, m_arsize, m_arlen, m_arburst},
              {1'b1, lr_addr, lr_size, 8'd0, 2'b01});
        check("lr_grant", {ifu_arready, lsu_arready, lsu_awready, lsu_wready, m_awvalid,
                           m_wvalid}, 6'b010000);
        tick();
        pend_lr = 1'b0; drive_masters(); m_arready = 1'b0;
        if (waits < 0) waits = $urandom_range(0, 4);
        repeat (waits) begin
          v = 1'($urandom_range(0, 1));
          m_rvalid = v; m_rlast = 1'($urandom_range(0, 1)); lsu_rready = 1'b0;
          #1;
          check("lr_stall", {m_rready, lsu_rvalid}, {1'b0, v});
          tick();
        end
        d = $urandom; rs = pick_resp();
        m_rvalid = 1'b1; m_rdata = d; m_rresp = rs; m_rlast = 1'($urandom_range(0, 1));
        lsu_rready = 1'b1;
        #1;
        check("lr_r", {lsu_rvalid, lsu_rdata, lsu_rresp, m_rready}, {1'b1, d, rs, 1'b1});
        check("lr_r_other", {ifu_rvalid, ifu_rdata, lsu_bvalid}, '0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
      end
      default: begin
        check("lw_aw", {m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb},
              {1'b1, lw_addr, 1'b1, lw_data, lw_strb});
        check("lw_grant", {ifu_arready, lsu_arready, lsu_awready, lsu_wready, m_arvalid},
              5'b00110);
        tick();
        pend_lw = 1'b0; drive_masters();
        if (waits < 0) waits = $urandom_range(0, 5);
        repeat (waits) begin
          lsu_bready = 1'($urandom_range(0, 1));
          #1;
          check("lw_wait", {lsu_bvalid, ifu_arready, m_bready}, {1'b0, 1'b0, lsu_bready});
          tick();
        end
        rs = pick_resp();
        m_bvalid = 1'b1; m_bresp = rs; lsu_bready = 1'b1;
        #1;
        check("lw_b", {lsu_bvalid, lsu_bresp, m_bready, ifu_arready, ifu_rvalid},
              {1'b1, rs, 1'b1, 1'b0, 1'b0});
        tick();
        m_bvalid = 1'b0;
      end
    endcase
  endtask

  initial begin
    rst = 1'b1;
    pend_ifu = 1'b0; pend_lr = 1'b0; pend_lw = 1'b0;
    ifu_addr = '0; ifu_len = '0; ifu_size = '0; ifu_burst = '0;
    lr_addr = '0; lr_size = '0; lw_addr = '0; lw_data = '0; lw_strb = '0;
    drive_masters();
    ifu_rready = 1'b0; lsu_rready = 1'b0; lsu_bready = 1'b0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_bresp = '0; m_bvalid = 1'b0;
    tick();
    tick();
    check("reset_out", {timeout_err, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                        ifu_arready, lsu_arready, lsu_awready, ifu_rvalid, lsu_rvalid,
                        lsu_bvalid}, '0);
    check("reset_payload", {m_araddr, m_awaddr}, '0);
    rst = 1'b0;

    // Contention from reset: IFU, then LSU, then a fresh pair alternates again.
    req_ifu(32'h8000_0000, 8'd0, 2'b01);
    req_lr(32'h1000_0004, 3'd2);
    serve(0);
    serve(0);
    req_ifu(32'h8000_0010, 8'd1, 2'b01);
    req_lr(32'h1000_0008, 3'd2);
    serve(0);
    serve(0);

    // Single IFU burst; the next tie must then go to the LSU.
    req_ifu(32'h3000_0000, 8'd3, 2'b01);
    serve(0);
    req_ifu(32'h3000_0010, 8'd0, 2'b01);
    req_lr(32'h1000_000c, 3'd1);
    serve(0);
    serve(0);

    // LSU write with the write response held back five cycles.
    req_lw(32'h1000_0000, 32'h0000_0041, 4'h1);
    serve(5);

    // Simultaneous LSU write and read: write first, one IDLE, then the read.
    req_lw(32'h1000_0020, 32'hdead_beef, 4'hf);
    req_lr(32'h1000_0024, 3'd2);
    serve(1);
    serve(0);

    // Error responses pass through untouched.
    fix_resp = 2;
    req_lr(32'h1000_0030, 3'd2);
    serve(0);
    fix_resp = -1;

    for (int i = 0; i < 60; i++) begin
      if (!pend_ifu && $urandom_range(0, 1) == 1)
        req_ifu($urandom, 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if (!pend_lr && $urandom_range(0, 1) == 1) req_lr($urandom, 3'($urandom_range(0, 2)));
      if (!pend_lw && $urandom_range(0, 2) == 2)
        req_lw($urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!(pend_ifu || pend_lr || pend_lw)) req_lr($urandom, 3'd2);
      serve(-1);
    end
    while (pend_ifu || pend_lr || pend_lw) serve(-1);

    // Watchdog: an IFU grant the slave never answers; afterwards reset clears everything.
    req_ifu(32'h3000_0100, 8'd3, 2'b01);
    drive_masters();
    m_arready = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
    tick();
    check("to_grant", m_arvalid, 1'b1);
    repeat (6) tick();
    check("to_early", timeout_err, 1'b0);
    repeat (3) tick();
    check("to_set", timeout_err, 1'b1);
    repeat (4) tick();
    check("to_sticky", {timeout_err, m_arvalid}, 2'b11);
    rst = 1'b1;
    tick();
    check("to_reset", {timeout_err, m_arvalid, ifu_arready, m_rready}, '0);
    rst = 1'b0;
    pend_ifu = 1'b0;
    grants.delete();

    // After reset the tie goes back to the IFU even though the last grant was an IFU one.
    req_ifu(32'h8000_0040, 8'd0, 2'b01);
    req_lr(32'h1000_0040, 3'd2);
    serve(0);
    serve(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_arbiter.md
# ysyx_25040129_arbiter

Two-master AXI4 arbiter that shares the single core-side memory port between the instruction fetch unit (IFU, read-only, burst-capable) and the load/store unit (LSU, single-beat read/write). Its master port drives the crossbar's upstream AXI slave port. It grants one whole transaction at a time, from address handshake to final response, and alternates grants round-robin under contention. A watchdog flags any transaction that never completes.

## Interface
- TIMEOUT_CYCLES, default 4096: cycles a granted transaction may stay open before timeout_err is set; must be ≥ 2.
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- ifu_araddr/arsize/arlen/arburst  input  32/3/8/2  IFU read address payload
- ifu_arvalid  input  1;  ifu_arready  output  1
- ifu_rdata/rresp/rlast  output  32/2/1  IFU read data
- ifu_rvalid  output  1;  ifu_rready  input  1
- lsu_araddr/arsize  input  32/3  LSU read address payload
- lsu_arvalid  input  1;  lsu_arready  output  1
- lsu_rdata/rresp  output  32/2;  lsu_rvalid  output  1;  lsu_rready  input  1
- lsu_awaddr  input  32;  lsu_awvalid  input  1;  lsu_awready  output  1
- lsu_wdata/wstrb  input  32/4;  lsu_wvalid  input  1;  lsu_wready  output  1
- lsu_bresp  output  2;  lsu_bvalid  output  1;  lsu_bready  input  1
- m_araddr/arsize/arlen/arburst/arvalid  output  32/3/8/2/1;  m_arready  input  1
- m_rdata/rresp/rlast/rvalid  input  32/2/1/1;  m_rready  output  1
- m_awaddr/awvalid  output  32/1;  m_awready  input  1
- m_wdata/wstrb/wvalid  output  32/4/1;  m_wready  input  1
- m_bresp/bvalid  input  2/1;  m_bready  output  1
- timeout_err  output  1  sticky; set when a granted transaction exceeds TIMEOUT_CYCLES

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. A 1-bit register last_ifu records the master of the most recent grant; it resets to 0.
- Requests are sampled in IDLE only:
  - r_ifu = ifu_arvalid.
  - r_lw = lsu_awvalid && lsu_wvalid. A write needs both valids, matching the crossbar's admission rule.
  - r_lr = lsu_arvalid && !r_lw. Within the LSU, a write beats a read.
- Grant decision in IDLE:
  - Only the IFU requests: go to IFU_RD.
  - Only the LSU requests: go to LSU_WR if r_lw, else LSU_RD.
  - Both request: grant the IFU if last_ifu == 0, otherwise grant the LSU.
  - last_ifu is updated on every grant.
- Routing in a granted state: every channel of the granted master is passed combinationally to and from m_*.
- Values forced for LSU reads: m_arlen = 0, m_arburst = 2'b01.
- Outputs of the non-granted master:
  - All ready and valid outputs are 0.
  - Data and resp outputs are 0.
- Outputs in IDLE:
  - All m_* valid and ready outputs are 0.
  - m_* payload outputs are 0.
  - All upstream ready and valid outputs are 0.
- Transaction completion:
  - IFU_RD ends on the cycle where m_rvalid && ifu_rready && m_rlast.
  - LSU_RD ends on m_rvalid && lsu_rready. m_rlast is ignored because the LSU read is single-beat.
  - LSU_WR ends on m_bvalid && lsu_bready.
  - Completion moves the state to IDLE on the next edge.
- Responses are forwarded unchanged, including SLVERR/DECERR. The arbiter never aborts a transaction.
- Watchdog:
  - A 13-bit+ counter is cleared in IDLE and increments each cycle in a granted state.
  - When the count reaches TIMEOUT_CYCLES, timeout_err is set.
  - timeout_err clears only on rst. The state machine keeps waiting.

## Timing
- Reset values:
  - state = IDLE, last_ifu = 0, watchdog counter = 0.
  - timeout_err = 0.
  - All valid, ready and payload outputs are 0.
- Grant latency: a request visible in IDLE at edge N gives a granted state at N+1. The AR/AW handshake can then complete in the same cycle if the slave is ready. Minimum 1 cycle from request to m_*valid.
- Every transaction is followed by exactly one IDLE cycle. Back-to-back grant pitch is therefore (transaction length + 1).
- Upstream masters must hold valid and payload until their ready is seen. The arbiter adds no buffering.
- A request that arrives mid-transaction is ignored until IDLE.
- Reset mid-transaction: the state returns to IDLE on the reset edge and any in-flight response is dropped. Resetting the crossbar and slaves together is the system's responsibility.
- The LSU asserting arvalid and awvalid+wvalid together: the write is granted first. The read remains pending and competes in the next IDLE cycle.

## Test plan
- Single IFU burst:
  - Stimulus: ifu_araddr=0x3000_0000, arlen=3, arburst=INCR.
  - Required: m_arvalid rises 1 cycle after request; 4 beats reach the IFU; IDLE follows the rlast beat; last_ifu=1.
- Contention from reset:
  - Stimulus: IFU and LSU reads raised together.
  - Required: IFU granted first, then LSU; a second simultaneous pair grants IFU again (strict alternation).
- LSU write:
  - Stimulus: awaddr=0x1000_0000, wdata=0x41, wstrb=0x1, awvalid and wvalid together, with bvalid delayed 5 cycles.
  - Required: m_aw and m_w handshakes complete; lsu_bvalid mirrors m_bvalid; ifu_arready=0 throughout.
- LSU read and write simultaneous:
  - Required: write serviced first, then one IDLE cycle, then the read; m_arlen=0 and m_arburst=1 on the read.
- Error passthrough:
  - Stimulus: slave returns rresp=2'b10.
  - Required: the LSU receives rresp=2'b10 and the FSM returns to IDLE normally.
- Timeout and reset:
  - Stimulus: TIMEOUT_CYCLES=8, slave never answers.
  - Required: timeout_err=1 at cycle 8 of the grant and stays 1; asserting rst clears the state to IDLE and timeout_err to 0.
